arcade_video_timing_gen: RTL and testbench
==========================================

Name: arcade_video_timing_gen

Overview:
- Parametrised horizontal/vertical timing generator for arcade cores. It is the generalised successor of the fixed 768x264 Donkey Kong/Mario Bros counter.
- Produces pixel/line counters, flipped counters, blanking, sync, line/frame strobes and a V-clock, all driven by a pixel clock enable.
- Sits between the core clock domain and the tile/sprite/video-out pipelines. One instance per core, with timing set entirely by parameters.

Parameters:
- HW, 10, H counter width
- VW, 9, V counter width
- H_TOTAL, 768, pixels per line; H counts 0..H_TOTAL-1
- H_BL_START, 512, first blanked H count
- H_BL_END, 767, last blanked H count
- H_SY_START, 576, first H count with H_SYNCn low
- H_SY_END, 639, last H count with H_SYNCn low
- V_STEP_H, 576, H count at which V advances
- V_LAST, 255, last count before the jump
- V_JUMP, 504, V value after V_LAST; V then runs to 2^VW-1 and wraps to 0
- V_BL_START, 240, first blanked V count
- V_BL_END, 15, last blanked V count
- V_SY_START, 504, first V count with V_SYNCn low
- V_SY_END, 511, last V count with V_SYNCn low

Ports:
- I_CLK  in  1  core clock
- I_RST_n  in  1  reset, asynchronous, active-low
- I_CEN  in  1  pixel clock enable
- I_HFLIP  in  1  horizontal flip
- I_VFLIP  in  1  vertical flip
- H_CNT  out  HW  pixel counter
- V_CNT  out  VW  line counter
- HF_CNT  out  HW-1  H_CNT[HW-2:0] XOR {HW-1{I_HFLIP}}
- VF_CNT  out  VW-1  V_CNT[VW-2:0] XOR {VW-1{I_VFLIP}}
- H_BLANKn, V_BLANKn, C_BLANKn  out  1  blanking, active-low; C = ~(Hblank|Vblank)
- H_SYNCn, V_SYNCn  out  1  sync, active-low
- LINE_START  out  1  one-I_CLK pulse
- FRAME_START  out  1  one-I_CLK pulse
- VCKn  out  1  V-clock level; high while H in [H_SY_START, H_SY_END]

Behaviour:
- Reset, asynchronous and immediate:
  - H_CNT=0, V_CNT=0.
  - Blank registers take their decoded value for count (0,0); defaults give H_BLANKn=1, V_BLANKn=0.
  - H_SYNCn=1, V_SYNCn=1, VCKn=0, strobes=0.
  - Reset mid-line restarts at (0,0). No partial-line carry.
- All state changes only on I_CLK edges with I_CEN=1. If I_CEN=0, every output holds, and LINE_START/FRAME_START are 0.
- H: on a CEN tick, H_CNT <= (H_CNT==H_TOTAL-1) ? 0 : H_CNT+1.
- V advances on the CEN tick where H_CNT becomes V_STEP_H:
  - V_CNT==V_LAST -> V_JUMP
  - V_CNT==2^VW-1 -> 0
  - otherwise V_CNT+1
- Window decode is inclusive: x in [S,E]. If S>E the window wraps, i.e. x>=S or x<=E.
- Blank and sync outputs are registered from the next-count value, so they are aligned with the counters. Zero latency relative to H_CNT/V_CNT.
  - H_BLANKn=0 iff H_CNT in H blank window.
  - V_BLANKn=0 iff V_CNT in V blank window.
  - H_SYNCn and V_SYNCn follow their windows the same way.
- LINE_START=1 for one I_CLK cycle: the cycle after the CEN tick where H_CNT becomes 0.
- FRAME_START=1 for one I_CLK cycle: the same cycle as LINE_START, when V_CNT is also 0.
- Flip outputs are combinational XOR of the live flip inputs. No resynchronisation.
- Legal-parameter contract, checked by an elaboration-time error:
  - H_TOTAL <= 2^HW
  - V_LAST < V_JUMP <= 2^VW-1
  - all H parameters < H_TOTAL
- Lines per frame = V_LAST+1 + 2^VW - V_JUMP (default 264).

Optional Feature:
- Macro VTG_SCREEN_OFFSET_EN.
- Defined:
  - Adds ports I_H_OFFSET (in, 4, signed) and I_V_OFFSET (in, 4, signed).
  - H sync window is shifted by I_H_OFFSET pixels. V sync window is shifted by I_V_OFFSET lines.
  - Shifts are modulo H_TOTAL and modulo the V sequence respectively.
  - Offsets are sampled into internal registers only on the FRAME_START tick. Changes mid-frame take effect next frame.
  - Sampled offsets reset to 0.
  - Blanking, counters and VCKn are unaffected.
- Undefined: ports absent, offsets fixed at 0.

Test Plan:
- Reset release, I_CEN=1 constant -> H_CNT 0..767 then 0; LINE_START pulses every 768 clocks; V_CNT goes 0→1 on the tick where H_CNT becomes 576.
- Run one full frame -> V sequence 0..255, 504..511, 0; FRAME_START period 264*768 CEN ticks; V_SYNCn low exactly while V_CNT in 504..511.
- Check blanking at (H,V)=(511,100),(512,100),(767,100),(0,239),(0,240),(0,15),(0,16) -> C_BLANKn = 1,0,0,1,0,0,1.
- I_CEN toggling 1-of-4, I_VFLIP=1 at V_CNT=0x23 -> all outputs advance at quarter rate; VF_CNT=0xDC; HF_CNT tracks ~H_CNT[8:0].
- Assert I_RST_n low at H_CNT=300, V_CNT=100 -> all counters 0 and H_SYNCn=1 immediately, without waiting for a clock edge; normal restart after release.
- With VTG_SCREEN_OFFSET_EN, I_H_OFFSET=+3 set mid-frame -> no H_SYNCn change until after FRAME_START; then H_SYNCn low for H_CNT 579..642.

Source files
------------

// File: rtl/arcade_video_timing_gen.sv
// Parametrised H/V timing generator for arcade cores.
// Counters, flipped counters, blanking, sync, line/frame strobes and V-clock,
// all advancing on the pixel clock enable I_CEN.
// Optional: define VTG_SCREEN_OFFSET_EN to add signed sync-window offsets
// (I_H_OFFSET, I_V_OFFSET) latched once per frame.
module arcade_video_timing_gen #(
  parameter int HW         = 10,
  parameter int VW         = 9,
  parameter int H_TOTAL    = 768,
  parameter int H_BL_START = 512,
  parameter int H_BL_END   = 767,
  parameter int H_SY_START = 576,
  parameter int H_SY_END   = 639,
  parameter int V_STEP_H   = 576,
  parameter int V_LAST     = 255,
  parameter int V_JUMP     = 504,
  parameter int V_BL_START = 240,
  parameter int V_BL_END   = 15,
  parameter int V_SY_START = 504,
  parameter int V_SY_END   = 511
) (
  input  logic                 I_CLK,
  input  logic                 I_RST_n,
  input  logic                 I_CEN,
  input  logic                 I_HFLIP,
  input  logic                 I_VFLIP,
`ifdef VTG_SCREEN_OFFSET_EN
  input  logic signed [3:0]    I_H_OFFSET,
  input  logic signed [3:0]    I_V_OFFSET,
`endif
  output logic [HW-1:0]        H_CNT,
  output logic [VW-1:0]        V_CNT,
  output logic [HW-2:0]        HF_CNT,
  output logic [VW-2:0]        VF_CNT,
  output logic                 H_BLANKn,
  output logic                 V_BLANKn,
  output logic                 C_BLANKn,
  output logic                 H_SYNCn,
  output logic                 V_SYNCn,
  output logic                 LINE_START,
  output logic                 FRAME_START,
  output logic                 VCKn
);

  localparam int V_LINES = V_LAST + 1 + (2 ** VW) - V_JUMP;

  // Parameter legality, rejected at elaboration
  if (H_TOTAL > 2 ** HW) begin : g_chk_htotal
    $error("H_TOTAL does not fit in HW bits");
  end
  if (!(V_LAST < V_JUMP && V_JUMP <= 2 ** VW - 1)) begin : g_chk_vjump
    $error("need V_LAST < V_JUMP <= 2**VW-1");
  end
  if (H_BL_START >= H_TOTAL || H_BL_END >= H_TOTAL || H_SY_START >= H_TOTAL ||
      H_SY_END >= H_TOTAL || V_STEP_H >= H_TOTAL) begin : g_chk_hparams
    $error("H parameters must be below H_TOTAL");
  end

  // Inclusive window; S>E means the window wraps through zero
  function automatic logic in_win(input int x, input int s, input int e);
    if (s <= e) return (x >= s) && (x <= e);
    return (x >= s) || (x <= e);
  endfunction

  // Undo an H shift modulo the line length
  function automatic int h_unshift(input int x, input int off);
    int t;
    t = x - off;
    if (t < 0) t = t + H_TOTAL;
    else if (t >= H_TOTAL) t = t - H_TOTAL;
    return t;
  endfunction

  // V value <-> position in the line sequence (0..V_LAST, V_JUMP..2^VW-1)
  function automatic int v_to_idx(input int v);
    return (v <= V_LAST) ? v : v - V_JUMP + V_LAST + 1;
  endfunction

  function automatic int idx_to_v(input int i);
    return (i <= V_LAST) ? i : i + V_JUMP - V_LAST - 1;
  endfunction

  // Undo a V shift modulo the frame's line sequence
  function automatic int v_unshift(input int v, input int off);
    int t;
    t = v_to_idx(v) - off;
    if (t < 0) t = t + V_LINES;
    else if (t >= V_LINES) t = t - V_LINES;
    return idx_to_v(t);
  endfunction

  localparam logic RST_H_BLANKN = !in_win(0, H_BL_START, H_BL_END);
  localparam logic RST_V_BLANKN = !in_win(0, V_BL_START, V_BL_END);

  logic [HW-1:0]      h_nxt;
  logic [VW-1:0]      v_adv;
  logic [VW-1:0]      v_nxt;
  logic               frame_tick;
  logic signed [3:0]  h_off_nxt;
  logic signed [3:0]  v_off_nxt;
  logic               h_bl_nxt, v_bl_nxt, h_sy_nxt, v_sy_nxt, vck_nxt;

  // Next counter values for a CEN tick
  always_comb begin
    h_nxt = (H_CNT == HW'(H_TOTAL - 1)) ? '0 : H_CNT + HW'(1);
    if (V_CNT == VW'(V_LAST))  v_adv = VW'(V_JUMP);
    else if (V_CNT == '1)      v_adv = '0;
    else                       v_adv = V_CNT + VW'(1);
    v_nxt = (h_nxt == HW'(V_STEP_H)) ? v_adv : V_CNT;
  end

  assign frame_tick = I_CEN && (h_nxt == '0) && (v_nxt == '0);

`ifdef VTG_SCREEN_OFFSET_EN
  logic signed [3:0] h_off_q;
  logic signed [3:0] v_off_q;

  // Offsets latched at frame start so a frame never mixes old and new sync positions
  always_ff @(posedge I_CLK or negedge I_RST_n) begin
    if (!I_RST_n) begin
      h_off_q <= '0;
      v_off_q <= '0;
    end else if (frame_tick) begin
      h_off_q <= I_H_OFFSET;
      v_off_q <= I_V_OFFSET;
    end
  end

  assign h_off_nxt = frame_tick ? I_H_OFFSET : h_off_q;
  assign v_off_nxt = frame_tick ? I_V_OFFSET : v_off_q;
`else
  assign h_off_nxt = 4'sd0;
  assign v_off_nxt = 4'sd0;
`endif

  // Window decode of the next counts, so registered outputs align with the counters
  always_comb begin
    h_bl_nxt = in_win(int'(h_nxt), H_BL_START, H_BL_END);
    v_bl_nxt = in_win(int'(v_nxt), V_BL_START, V_BL_END);
    h_sy_nxt = in_win(h_unshift(int'(h_nxt), int'(h_off_nxt)), H_SY_START, H_SY_END);
    v_sy_nxt = in_win(v_unshift(int'(v_nxt), int'(v_off_nxt)), V_SY_START, V_SY_END);
    vck_nxt  = in_win(int'(h_nxt), H_SY_START, H_SY_END);
  end

  // Counter and timing-output registers, advanced only on CEN ticks
  always_ff @(posedge I_CLK or negedge I_RST_n) begin
    if (!I_RST_n) begin
      H_CNT       <= '0;
      V_CNT       <= '0;
      H_BLANKn    <= RST_H_BLANKN;
      V_BLANKn    <= RST_V_BLANKN;
      H_SYNCn     <= 1'b1;
      V_SYNCn     <= 1'b1;
      VCKn        <= 1'b0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
      if (I_CEN) begin
        H_CNT       <= h_nxt;
        V_CNT       <= v_nxt;
        H_BLANKn    <= !h_bl_nxt;
        V_BLANKn    <= !v_bl_nxt;
        H_SYNCn     <= !h_sy_nxt;
        V_SYNCn     <= !v_sy_nxt;
        VCKn        <= vck_nxt;
        LINE_START  <= (h_nxt == '0);
        FRAME_START <= frame_tick;
      end
    end
  end

  assign HF_CNT   = H_CNT[HW-2:0] ^ {(HW-1){I_HFLIP}};
  assign VF_CNT   = V_CNT[VW-2:0] ^ {(VW-1){I_VFLIP}};
  assign C_BLANKn = H_BLANKn & V_BLANKn;

endmodule

// File: tb/tb_arcade_video_timing_gen.sv
// Scoreboard bench for arcade_video_timing_gen, using a scaled-down timing so
// whole frames fit in a short run. Expected outputs come from a position model:
// after n CEN ticks, H = n mod H_TOTAL and the line index counts V_STEP_H crossings.
module tb_arcade_video_timing_gen;

  localparam int HW    = 7;
  localparam int VW    = 6;
  localparam int HT    = 96;
  localparam int HBS   = 64;
  localparam int HBE   = 95;
  localparam int HSS   = 72;
  localparam int HSE   = 79;
  localparam int VSTEP = 72;
  localparam int VL    = 31;
  localparam int VJ    = 56;
  localparam int VBS   = 30;
  localparam int VBE   = 1;
  localparam int VSS   = 56;
  localparam int VSE   = 59;
  localparam int LINES = VL + 1 + (1 << VW) - VJ;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cen = 1'b0;
  logic hflip = 1'b0;
  logic vflip = 1'b0;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [HW-2:0] hf_cnt;
  logic [VW-2:0] vf_cnt;
  logic h_blank_n, v_blank_n, c_blank_n, h_sync_n, v_sync_n;
  logic line_start, frame_start, vck_n;

`ifdef VTG_SCREEN_OFFSET_EN
  logic signed [3:0] h_off = 4'sd0;
  logic signed [3:0] v_off = 4'sd0;
`endif

  arcade_video_timing_gen #(
    .HW(HW), .VW(VW), .H_TOTAL(HT),
    .H_BL_START(HBS), .H_BL_END(HBE), .H_SY_START(HSS), .H_SY_END(HSE),
    .V_STEP_H(VSTEP), .V_LAST(VL), .V_JUMP(VJ),
    .V_BL_START(VBS), .V_BL_END(VBE), .V_SY_START(VSS), .V_SY_END(VSE)
  ) dut (
    .I_CLK(clk),
    .I_RST_n(rst_n),
    .I_CEN(cen),
    .I_HFLIP(hflip),
    .I_VFLIP(vflip),
`ifdef VTG_SCREEN_OFFSET_EN
    .I_H_OFFSET(h_off),
    .I_V_OFFSET(v_off),
`endif
    .H_CNT(h_cnt),
    .V_CNT(v_cnt),
    .HF_CNT(hf_cnt),
    .VF_CNT(vf_cnt),
    .H_BLANKn(h_blank_n),
    .V_BLANKn(v_blank_n),
    .C_BLANKn(c_blank_n),
    .H_SYNCn(h_sync_n),
    .V_SYNCn(v_sync_n),
    .LINE_START(line_start),
    .FRAME_START(frame_start),
    .VCKn(vck_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h; int v; int hf; int vf;
    int hbn; int vbn; int cbn; int hsn; int vsn; int vck; int ls; int fs;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_chk = 0;
  int n_fail = 0;
  longint ticks = 0;
  bit cen_last = 1'b0;
  int cen_mode = 0;
  int cyc = 0;

  function automatic int win(input int x, input int s, input int e);
    if (s <= e) return (x >= s && x <= e) ? 1 : 0;
    return (x >= s || x <= e) ? 1 : 0;
  endfunction

  // Expected outputs after n CEN ticks since reset
  function automatic exp_t model(input longint n, input bit ticked, input bit hfl, input bit vfl);
    exp_t e;
    int idx;
    int hmask;
    int vmask;
    hmask = (1 << (HW - 1)) - 1;
    vmask = (1 << (VW - 1)) - 1;
    e.h   = int'(n % HT);
    idx   = int'(((n + HT - VSTEP) / HT) % LINES);
    e.v   = (idx <= VL) ? idx : idx + VJ - (VL + 1);
    e.hf  = (e.h ^ (hfl ? hmask : 0)) & hmask;
    e.vf  = (e.v ^ (vfl ? vmask : 0)) & vmask;
    e.hbn = 1 - win(e.h, HBS, HBE);
    e.vbn = 1 - win(e.v, VBS, VBE);
    e.cbn = e.hbn & e.vbn;
    e.hsn = 1 - win(e.h, HSS, HSE);
    e.vsn = 1 - win(e.v, VSS, VSE);
    e.vck = win(e.h, HSS, HSE);
    e.ls  = (ticked && e.h == 0) ? 1 : 0;
    e.fs  = (e.ls == 1 && e.v == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d expected %0d (tick %0d)", nm, $time, act, exp_v, ticks);
    end
  endtask

  task automatic check_all(input exp_t e);
    chk("H_CNT", 32'(h_cnt), e.h);
    chk("V_CNT", 32'(v_cnt), e.v);
    chk("HF_CNT", 32'(hf_cnt), e.hf);
    chk("VF_CNT", 32'(vf_cnt), e.vf);
    chk("H_BLANKn", 32'(h_blank_n), e.hbn);
    chk("V_BLANKn", 32'(v_blank_n), e.vbn);
    chk("C_BLANKn", 32'(c_blank_n), e.cbn);
    chk("H_SYNCn", 32'(h_sync_n), e.hsn);
    chk("V_SYNCn", 32'(v_sync_n), e.vsn);
    chk("VCKn", 32'(vck_n), e.vck);
    chk("LINE_START", 32'(line_start), e.ls);
    chk("FRAME_START", 32'(frame_start), e.fs);
  endtask

  // Monitor: every pushed expectation is compared at the following falling edge
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      check_all(mon_e);
    end
  end

  task automatic drive_inputs();
    cyc++;
    case (cen_mode)
      0:       cen = 1'b1;
      1:       cen = ($urandom_range(0, 3) != 0);
      default: cen = (cyc % 4 == 0);
    endcase
    if ($urandom_range(0, 31) == 0) hflip = ~hflip;
    if ($urandom_range(0, 31) == 0) vflip = ~vflip;
  endtask

  task automatic step();
    @(posedge clk);
    if (cen) ticks++;
    cen_last = cen;
    #1;
    drive_inputs();
    sb.push_back(model(ticks, cen_last, hflip, vflip));
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ticks = 0;
    cen_last = 1'b0;
    drive_inputs();
    sb.push_back(model(0, 1'b0, hflip, vflip));
  endtask

  initial begin
    bit found;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all(model(0, 1'b0, hflip, vflip));

    release_reset();
    cen_mode = 0;
    repeat (4000) step();
    cen_mode = 2;
    vflip = 1'b1;
    repeat (2000) step();
    cen_mode = 1;
    repeat (3000) step();

    // Walk into the sync window, then reset asynchronously mid-cycle
    cen_mode = 0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (int'(ticks % HT) == HSS + 2) found = 1'b1;
    end
    chk("reach_sync_window", 32'(found), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all(model(0, 1'b0, hflip, vflip));
    repeat (3) @(posedge clk);
    release_reset();
    cen_mode = 1;
    repeat (3000) step();

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
